mips_dmem_arbiter: RTL and testbench

//   Shares the single-ported mips_data_memory between two requesters: port 0 (CPU MEM stage) and port 1 (DMA/debug).

---
 rtl/mips_mem_pkg.sv | 54 +++++
 rtl/mips_rr_arbiter2.sv | 46 ++++
 rtl/mips_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
//   Shared definitions for the data-memory arbiter:
//   - MIPS load/store opcode encodings (OP_LB .. OP_SW)
//   - opcode classification helpers (is_legal / is_load / is_store)
//   - natural-alignment helper (is_aligned) for halfword/word accesses
//   - arbiter FSM state encoding and the default memory read latency
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int unsigned MEM_RD_LAT_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_legal = 1'b1;
      default:                                                  is_legal = 1'b0;
    endcase
  endfunction

  // Bit 3 of every legal opcode separates stores (1) from loads (0).
  function automatic logic is_store(input logic [5:0] op);
    is_store = is_legal(op) && op[3];
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    is_load = is_legal(op) && !op[3];
  endfunction

  // Byte accesses are always aligned; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_aligned = (addr_lo[0] == 1'b0);
      OP_LW, OP_SW:         is_aligned = (addr_lo == 2'b00);
      default:              is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mips_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// mips_rr_arbiter2
//   Two-way request arbiter. A lone requester always wins. When both request,
//   FIXED_PRIO!=0 always picks requester 0; otherwise the requester not served
//   last wins. The "served last" pointer only moves when accept_i confirms
//   that the current grant was taken.
// Ports
//   clk       in   clock
//   rst_n     in   synchronous active-low reset (pointer favours requester 0)
//   req_i     in   [1:0] request vector
//   accept_i  in   grant taken this cycle, update pointer
//   gnt_o     out  [1:0] one-hot grant (combinational), 0 when no request
// ---------------------------------------------------------------------------
module mips_rr_arbiter2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 was served last, so requester 0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    gnt_o  = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ((FIXED_PRIO != 0) || last_q) ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_dmem_arbiter
//   Shares one single-ported mips_data_memory between port 0 (CPU MEM stage)
//   and port 1 (DMA/debug). One request in flight at a time:
//     IDLE -> ACCESS -> WAIT x MEM_RD_LAT (loads only) -> RESP -> IDLE
//   Requests with an illegal opcode still pass through the ACCESS slot but
//   raise no memory strobe, and answer with resp_err=1, rdata=0.
// Configuration macro
//   DMEM_ARB_ALIGN_CHECK_EN : when defined, misaligned lh/lhu/sh (addr[0]!=0)
//   and lw/sw (addr[1:0]!=0) are treated like illegal requests (no access,
//   resp_err=1). When undefined, addresses go to memory unchecked.
// Parameters
//   MEM_RD_LAT  cycles from mem_read strobe to valid mem_read_data (0..3)
//   FIXED_PRIO  0 = round-robin, 1 = port 0 wins simultaneous requests
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   pN_req_valid/ready             request handshake (ready only in IDLE)
//   pN_req_opcode/addr/wdata       request contents, latched on handshake
//   pN_resp_valid/rdata/err        one-cycle response on the owning port
//   mem_address/data_in/opcode     memory buses, hold last value when idle
//   mem_write/mem_read             memory strobes (ACCESS/WAIT only)
//   mem_read_data                  memory read data
// ---------------------------------------------------------------------------
module mips_dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = MEM_RD_LAT_DEFAULT,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [5:0]  p0_req_opcode,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [5:0]  p1_req_opcode,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,

  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [5:0]  mem_opcode,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  // Last WAIT cycle index; the counter starts at 1 on the first WAIT cycle.
  localparam logic [1:0] LAT_LAST = 2'(MEM_RD_LAT);

  arb_state_e  state_q, state_d;
  logic        port_q, port_d;        // owner of the in-flight request
  logic        load_q, load_d;        // in-flight request reads memory
  logic        err_q, err_d;          // in-flight request will be refused
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [5:0]  mem_op_q, mem_op_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_rd_q, mem_rd_d;

  logic [1:0]  gnt;
  logic        idle;
  logic        hs;
  logic        sel;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ok;

  mips_rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({p1_req_valid, p0_req_valid}),
    .accept_i (hs),
    .gnt_o    (gnt)
  );

  // Ready is suppressed while reset is asserted so no handshake is reported
  // for a request that the reset would discard.
  assign idle         = (state_q == ST_IDLE) && rst_n;
  assign p0_req_ready = idle && gnt[0];
  assign p1_req_ready = idle && gnt[1];
  assign hs           = idle && (gnt != 2'b00);

  assign sel       = gnt[1];
  assign req_op    = sel ? p1_req_opcode : p0_req_opcode;
  assign req_addr  = sel ? p1_req_addr   : p0_req_addr;
  assign req_wdata = sel ? p1_req_wdata  : p0_req_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign req_ok = is_legal(req_op) && is_aligned(req_op, req_addr[1:0]);
`else
  assign req_ok = is_legal(req_op);
`endif

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    load_d      = load_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_op_d    = mem_op_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          port_d  = sel;
          load_d  = req_ok && is_load(req_op);
          err_d   = !req_ok;
          rdata_d = '0;
          cnt_d   = 2'd0;
          state_d = ST_ACCESS;
          // The memory buses double as the request latch; a refused request
          // leaves them untouched so they keep showing the last real access.
          if (req_ok) begin
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            mem_op_d    = req_op;
            mem_wr_d    = is_store(req_op);
            mem_rd_d    = is_load(req_op);
          end
        end
      end

      ST_ACCESS: begin
        mem_wr_d = 1'b0;
        state_d  = ST_RESP;
        if (load_q) begin
          if (MEM_RD_LAT == 0) begin
            rdata_d  = mem_read_data;
            mem_rd_d = 1'b0;
          end else begin
            cnt_d   = 2'd1;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rdata_d  = mem_read_data;
          mem_rd_d = 1'b0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_wr_d = 1'b0;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= 1'b0;
      load_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_op_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      load_q      <= load_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_op_q    <= mem_op_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
    end
  end

  assign mem_address = mem_addr_q;
  assign mem_data_in = mem_wdata_q;
  assign mem_opcode  = mem_op_q;
  assign mem_write   = mem_wr_q;
  assign mem_read    = mem_rd_q;

  assign p0_resp_valid = (state_q == ST_RESP) && !port_q;
  assign p1_resp_valid = (state_q == ST_RESP) &&  port_q;
  assign p0_resp_err   = p0_resp_valid && err_q;
  assign p1_resp_err   = p1_resp_valid && err_q;
  assign p0_resp_rdata = p0_resp_valid ? rdata_q : '0;
  assign p1_resp_rdata = p1_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_dmem_arbiter
//   Directed stimulus with a response scoreboard. Instance "a" is round-robin
//   with MEM_RD_LAT=1 and a small memory model; instance "b" uses fixed
//   priority and is used for the starvation scenario only.
// ---------------------------------------------------------------------------
module tb_mips_dmem_arbiter;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_err;
  logic [5:0]  p0_req_opcode;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_resp_valid, p1_resp_err;
  logic [5:0]  p1_req_opcode;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_read_data;
  logic [5:0]  mem_opcode;
  logic        mem_write, mem_read;

  logic        b_p0_req_valid, b_p0_req_ready, b_p0_resp_valid, b_p0_resp_err;
  logic [31:0] b_p0_resp_rdata;
  logic        b_p1_req_valid, b_p1_req_ready, b_p1_resp_valid, b_p1_resp_err;
  logic [31:0] b_p1_resp_rdata;
  logic [31:0] b_mem_address, b_mem_data_in;
  logic [5:0]  b_mem_opcode;
  logic        b_mem_write, b_mem_read;
  logic [31:0] b_mem_read_data;
  assign b_mem_read_data = 32'h0;

  mips_dmem_arbiter #(.MEM_RD_LAT(1), .FIXED_PRIO(0)) a (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_opcode(p0_req_opcode),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
    .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_opcode(p1_req_opcode),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
    .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_opcode(mem_opcode),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  mips_dmem_arbiter #(.MEM_RD_LAT(1), .FIXED_PRIO(1)) b (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(b_p0_req_valid), .p0_req_ready(b_p0_req_ready), .p0_req_opcode(OP_SW),
    .p0_req_addr(32'h100), .p0_req_wdata(32'h1), .p0_resp_valid(b_p0_resp_valid),
    .p0_resp_rdata(b_p0_resp_rdata), .p0_resp_err(b_p0_resp_err),
    .p1_req_valid(b_p1_req_valid), .p1_req_ready(b_p1_req_ready), .p1_req_opcode(OP_SW),
    .p1_req_addr(32'h200), .p1_req_wdata(32'h2), .p1_resp_valid(b_p1_resp_valid),
    .p1_resp_rdata(b_p1_resp_rdata), .p1_resp_err(b_p1_resp_err),
    .mem_address(b_mem_address), .mem_data_in(b_mem_data_in), .mem_opcode(b_mem_opcode),
    .mem_write(b_mem_write), .mem_read(b_mem_read), .mem_read_data(b_mem_read_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;   // -1: latency not checked
    int          hs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   gnt_log[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  logic [5:0]  last_wr_op = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory model: registered read, one cycle after the read strobe is seen.
  logic [31:0] mem_model [int];
  logic [31:0] rd_data = '0;
  assign mem_read_data = rd_data;
  initial forever begin
    @(posedge clk);
    if (mem_read)
      rd_data <= mem_model.exists(int'(mem_address[9:2])) ? mem_model[int'(mem_address[9:2])] : 32'h0;
    if (mem_write && mem_opcode == OP_SW)
      mem_model[int'(mem_address[9:2])] = mem_data_in;
  end

  // Monitor / scoreboard for instance a.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mem_write) begin
      wr_cnt++;
      last_wr_op   = mem_opcode;
      last_wr_addr = mem_address;
      last_wr_data = mem_data_in;
    end
    if (mem_read) rd_cnt++;
    if (mem_read || mem_write) chk("strobe_exclusive", {31'b0, mem_read && mem_write}, 32'h0);
    if (p0_resp_valid) begin
      if (q0.size() == 0) chk("p0_unexpected_resp", 32'h1, 32'h0);
      else begin
        e = q0.pop_front();
        chk("p0_rdata", p0_resp_rdata, e.rdata);
        chk("p0_err", {31'b0, p0_resp_err}, {31'b0, e.err});
        if (e.lat >= 0) chk("p0_latency", cyc - e.hs, e.lat);
      end
    end
    if (p1_resp_valid) begin
      if (q1.size() == 0) chk("p1_unexpected_resp", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        chk("p1_rdata", p1_resp_rdata, e.rdata);
        chk("p1_err", {31'b0, p1_resp_err}, {31'b0, e.err});
        if (e.lat >= 0) chk("p1_latency", cyc - e.hs, e.lat);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int port, input logic v, input logic [5:0] op,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      p0_req_valid = v; p0_req_opcode = op; p0_req_addr = addr; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_opcode = op; p1_req_addr = addr; p1_req_wdata = wd;
    end
  endtask

  // Present a request, wait (bounded) for ready, push the expected response.
  task automatic issue(input int port, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input bit drop, output int waited);
    exp_t e;
    bit   got = 0;
    waited = 0;
    @(negedge clk);
    drive(port, 1'b1, op, addr, wd);
    while (!got && waited < 40) begin
      #1;
      if ((port == 0) ? p0_req_ready : p1_req_ready) got = 1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!got) begin
      chk("handshake_timeout", 32'h0, 32'h1);
    end else begin
      e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.hs = cyc;
      if (port == 0) q0.push_back(e); else q1.push_back(e);
      gnt_log.push_back(port);
    end
    @(posedge clk);
    #1;
    if (drop) drive(port, 1'b0, 6'b0, 32'h0, 32'h0);
  endtask

  task automatic port_stream(input int port, input int n, input logic [31:0] base);
    int w;
    for (int i = 0; i < n; i++)
      issue(port, OP_SW, base + 32'(4 * i), base + 32'(i), 32'h0, 1'b0, 2, (i == n - 1), w);
  endtask

  initial begin
    int w, w0, r0, g, n0, n1;
    bit got;
    rst_n = 1'b0;
    drive(0, 1'b0, 6'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 6'b0, 32'h0, 32'h0);
    b_p0_req_valid = 1'b0;
    b_p1_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_opcode", {26'b0, mem_opcode}, 32'h0);
    chk("rst_resp_valid", {30'b0, p1_resp_valid, p0_resp_valid}, 32'h0);
    chk("rst_ready", {30'b0, p1_req_ready, p0_req_ready}, 32'h0);
    rst_n = 1'b1;

    // Store word, then read it back.
    w0 = wr_cnt;
    issue(0, OP_SW, 32'h4, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 1'b1, w);
    chk("sw_ready_same_cycle", w, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("sw_write_pulses", wr_cnt - w0, 1);
    chk("sw_opcode", {26'b0, last_wr_op}, {26'b0, OP_SW});
    chk("sw_addr", last_wr_addr, 32'h4);
    chk("sw_data", last_wr_data, 32'hFFFF_FFFF);

    r0 = rd_cnt;
    issue(0, OP_LW, 32'h4, 32'h0, 32'hFFFF_FFFF, 1'b0, 3, 1'b1, w);
    repeat (4) @(negedge clk);
    #1;
    chk("lw_read_cycles", rd_cnt - r0, 2);

    issue(1, OP_SW, 32'h8, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b1, w);
    issue(0, OP_LW, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b1, w);
    issue(1, OP_LW, 32'hC, 32'h0, 32'h0, 1'b0, 3, 1'b1, w);

    // Illegal opcode on port 1.
    repeat (4) @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1, 6'b000000, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1, -1, 1'b1, w);
    repeat (4) @(negedge clk);
    #1;
    chk("illegal_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // Both ports continuously valid, round-robin; port 1 was served last.
    g = gnt_log.size();
    fork
      port_stream(0, 4, 32'h20);
      port_stream(1, 4, 32'h40);
    join
    for (int i = 0; i < 8; i++) chk("rr_order", gnt_log[g + i], i % 2);

    // Misaligned halfword store.
    repeat (4) @(negedge clk);
    w0 = wr_cnt;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    issue(0, OP_SH, 32'h1, 32'h0000_BEEF, 32'h0, 1'b1, 2, 1'b1, w);
    repeat (4) @(negedge clk);
    #1;
    chk("sh_misaligned_writes", wr_cnt - w0, 0);
`else
    issue(0, OP_SH, 32'h1, 32'h0000_BEEF, 32'h0, 1'b0, 2, 1'b1, w);
    repeat (4) @(negedge clk);
    #1;
    chk("sh_misaligned_writes", wr_cnt - w0, 1);
`endif

    // Reset while a port-1 load waits for memory data.
    @(negedge clk);
    drive(1, 1'b1, OP_LW, 32'h4, 32'h0);
    #1;
    chk("abort_ready", {31'b0, p1_req_ready}, 32'h1);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 6'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("abort_in_wait_read", {31'b0, mem_read}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_strobes", {30'b0, mem_read, mem_write}, 32'h0);
    chk("abort_no_resp", {30'b0, p1_resp_valid, p0_resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    g = gnt_log.size();
    fork
      port_stream(0, 1, 32'h60);
      port_stream(1, 1, 32'h80);
    join
    chk("post_reset_first_grant", gnt_log[g], 0);

    // Fixed priority: port 1 starves while port 0 stays valid.
    @(negedge clk);
    b_p0_req_valid = 1'b1;
    b_p1_req_valid = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      #1;
      if (b_p0_req_ready) n0++;
      if (b_p1_req_ready) n1++;
    end
    chk("fixed_p1_starved", n1, 0);
    chk("fixed_p0_grants", n0, 7);
    b_p0_req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      #1;
      if (b_p1_req_ready) got = 1;
    end
    chk("fixed_p1_after_p0_drop", {31'b0, got}, 32'h1);
    b_p1_req_valid = 1'b0;

    for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
